mav_alu_sequencer: RTL
======================

Name: mav_alu_sequencer

Overview:
- Controller for the 4-tap moving-average datapath.
- Holds a 4-entry circular sample buffer and sequences one shared 32-bit ALU instance over multiple cycles: three adds, then a divide-by-4 via shift.
- Sits between the debounced, edge-detected enable pulse and the display output, replacing the four parallel ALU instances with one time-multiplexed ALU.

Parameters:
- DW, 16, sample and output width.
- AW, 32, ALU operand/result width; must satisfy AW >= DW+2.
- F_ADD, 3'b001, ALU function code for a+b.
- F_SHR, 3'b101, ALU function code for logical a>>b.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  single-cycle sample strobe (already debounced and edge-detected).
- d  in  DW  input sample, valid when en=1.
- alu_a  out  AW  ALU operand a.
- alu_b  out  AW  ALU operand b.
- alu_f  out  3  ALU function select.
- alu_y  in  AW  ALU result, combinational from alu_a/alu_b/alu_f.
- m  out  DW  current output value, registered.
- m_valid  out  1  one-cycle pulse when m updates.
- busy  out  1  high while the ALU sequence runs.
- drop  out  1  sticky flag: an en arrived while busy.

Behaviour:
- Reset (async, rst=1): all of the following clear immediately, regardless of state.
  - m=0, m_valid=0, busy=0, drop=0.
  - Buffer entries = 0, write pointer wp=0, fill count cnt=0, accumulator acc=0.
  - State = IDLE.
  - rst overrides a simultaneous en.
- States: IDLE, ADD01, ADD2, ADD3, SHR. busy=1 in every state except IDLE.
- IDLE with en=1 (accepting edge E0):
  - buf[wp] <= d; wp <= wp+1, wrapping 3->0; cnt <= min(cnt+1, 4).
  - If cnt+1 < 4 (fill phase): m <= d, m_valid pulses after E0, state stays IDLE. The ALU is not used.
  - Otherwise: state <= ADD01.
- ADD01: alu_a={0,buf0}, alu_b={0,buf1}, alu_f=F_ADD; acc <= alu_y; next state ADD2.
- ADD2: alu_a=acc, alu_b={0,buf2}, alu_f=F_ADD; acc <= alu_y; next state ADD3.
- ADD3: alu_a=acc, alu_b={0,buf3}, alu_f=F_ADD; acc <= alu_y; next state SHR.
- SHR: alu_a=acc, alu_b=2, alu_f=F_SHR; m <= alu_y[DW-1:0]; m_valid pulses; next state IDLE.
- The buffer write at E0 is visible to ADD01, so the new sample is included in the sum.
- Latency: m updates at edge E4, 4 clocks after the accepting edge. A new en is accepted at E5 at the earliest.
- Arithmetic: operands are zero-extended to AW. The 4-sample sum needs at most DW+2 bits and never overflows AW. The result is truncated to DW, which is exact after the shift.
- In IDLE, alu_a=0, alu_b=0, alu_f=F_ADD. The ALU outputs are don't-care there but must be deterministic.
- en while busy: the sample is discarded; buffer, wp, cnt and the sequence are unaffected; drop <= 1 (sticky until rst).
- en is ignored when not in IDLE, including in the same cycle as the SHR->IDLE transition.
- m holds its value between updates. m_valid is never high for more than one cycle per accepted sample.
- After the first 4 samples, every accepted sample triggers a full ALU sequence (steady state). cnt stays saturated at 4.
- Reset mid-sequence: the sequence aborts, m returns to 0, and no m_valid pulse is issued. The next sample restarts the fill phase.

Test Plan:
- Fill phase: after rst, en with d=4, 8, 12 spaced 2 clocks apart -> m=4, 8, 12, each with a one-cycle m_valid the cycle after its en; busy stays 0; alu_f stays F_ADD.
- First average: then en with d=16 -> busy high for 4 cycles; alu_f sequence ADD, ADD, ADD, SHR; acc values 12, 24, 40; m=10 at E4 with one m_valid pulse.
- Wrap-around: then en with d=20 (overwrites buf0=4) -> m=14 after 4 clocks; wp back at 1.
- Width: four samples of 0xFFFF -> acc reaches 0x3FFFC; m=0xFFFF with no truncation error.
- Drop: en with d=100 on the cycle after an accepting edge -> sample not stored, drop=1 and stays 1; next average excludes 100.
- Reset mid-sequence: assert rst during ADD2 -> m=0, m_valid=0, busy=0, drop=0 immediately; after release, en with d=5 -> m=5 (fill phase).

Source files
------------

// File: rtl/mav_alu_sequencer.sv
// Purpose: 4-tap moving-average controller that time-multiplexes one external ALU
//          over three adds and a divide-by-4 shift. It also owns the 4-entry
//          circular sample buffer.
// Latency: during the fill phase (first 3 samples) m updates 1 clock after the
//          accepting edge. After that, m updates 4 clocks after the accepting edge.
// Backpressure: none. An en pulse that arrives while busy is discarded and sets
//          the sticky drop flag.
//
// Ports:
//   clk, rst        clock (rising edge) and async active-high reset
//   en, d           sample strobe and sample data
//   alu_a/b/f       operands and function select driven to the shared ALU
//   alu_y           combinational ALU result
//   m, m_valid      registered average and its one-cycle update pulse
//   busy, drop      sequence in progress; sticky "sample lost while busy"
//
// AW must be at least DW+2 so the 4-sample sum fits without overflow.
module mav_alu_sequencer #(
    parameter int         DW    = 16,
    parameter int         AW    = 32,
    parameter logic [2:0] F_ADD = 3'b001,
    parameter logic [2:0] F_SHR = 3'b101
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [AW-1:0] alu_a,
    output logic [AW-1:0] alu_b,
    output logic [2:0]    alu_f,
    input  logic [AW-1:0] alu_y,
    output logic [DW-1:0] m,
    output logic          m_valid,
    output logic          busy,
    output logic          drop
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD01 = 3'd1,
        S_ADD2  = 3'd2,
        S_ADD3  = 3'd3,
        S_SHR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] smp_q [4];
    logic [DW-1:0] smp_d [4];
    logic [1:0]    wp_q, wp_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] m_q, m_d;
    logic          m_valid_q, m_valid_d;
    logic          drop_q, drop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 4; i++) smp_q[i] <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < 4; i++) smp_q[i] <= smp_d[i];
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        for (int i = 0; i < 4; i++) smp_d[i] = smp_q[i];
        wp_d      = wp_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        m_valid_d = 1'b0;
        drop_d    = drop_q;
        // Idle drives fixed operands so the ALU output stays deterministic.
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = F_ADD;

        // Samples are only taken in IDLE. This includes the SHR->IDLE cycle,
        // where en is still counted as a loss.
        if (en && (state_q != S_IDLE)) drop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    smp_d[wp_q] = d;
                    wp_d        = wp_q + 2'd1;
                    cnt_d       = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
                    // Until four samples exist, the raw sample is shown directly.
                    if (cnt_q < 3'd3) begin
                        m_d       = d;
                        m_valid_d = 1'b1;
                    end else begin
                        state_d = S_ADD01;
                    end
                end
            end
            S_ADD01: begin
                alu_a   = AW'(smp_q[0]);
                alu_b   = AW'(smp_q[1]);
                acc_d   = alu_y;
                state_d = S_ADD2;
            end
            S_ADD2: begin
                alu_a   = acc_q;
                alu_b   = AW'(smp_q[2]);
                acc_d   = alu_y;
                state_d = S_ADD3;
            end
            S_ADD3: begin
                alu_a   = acc_q;
                alu_b   = AW'(smp_q[3]);
                acc_d   = alu_y;
                state_d = S_SHR;
            end
            S_SHR: begin
                alu_a     = acc_q;
                alu_b     = AW'(2);
                alu_f     = F_SHR;
                // Exact after the shift: sum < 4*2^DW, so sum>>2 fits in DW bits.
                m_d       = alu_y[DW-1:0];
                m_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m       = m_q;
    assign m_valid = m_valid_q;
    assign busy    = (state_q != S_IDLE);
    assign drop    = drop_q;

endmodule
